// File: rtl/prefetch_stride_issuer.sv
// rtl/prefetch_stride_issuer.sv - stride-trained prefetch issuer driving the queue command port.
// Optional PREFETCH_PAGE_BOUND_EN: stall prefetch issue when nextPrefAddr leaves lastAddr's page.
module prefetch_stride_issuer #(
  parameter int BA_ADDR_SIZE         = 64,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int LOG_QUEUE_SIZE       = 6,
  parameter int STRIDE_BITS          = 16,
  parameter int CONF_THRESHOLD       = 2,
  parameter int PREFETCH_DEPTH       = 4,
  parameter int MAX_OUTSTANDING      = 8
`ifdef PREFETCH_PAGE_BOUND_EN
  , parameter int PAGE_LOG           = 12
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      demValid,
  input  logic [BA_ADDR_SIZE-1:0]   demAddr,
  input  logic                      queueFull,
  input  logic [LOG_QUEUE_SIZE:0]   outstandingReqCnt,
  output logic                      qValid,
  output logic [1:0]                qOpcode,
  output logic [BA_ADDR_SIZE-1:0]   qAddr,
  output logic                      flush,
  output logic [STRIDE_BITS-1:0]    strideOut,
  output logic                      active
);

  localparam int CONF_W  = $clog2(CONF_THRESHOLD + 1);
  localparam int AHEAD_W = $clog2(PREFETCH_DEPTH + 1);
  localparam logic [CONF_W-1:0]  CONF_THR_L = CONF_W'(CONF_THRESHOLD);
  localparam logic [AHEAD_W-1:0] DEPTH_L    = AHEAD_W'(PREFETCH_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_ACTIVE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [BA_ADDR_SIZE-1:0]   r_last_addr, w_last_nxt;
  logic [STRIDE_BITS-1:0]    r_stride, w_stride_nxt;
  logic [CONF_W-1:0]         r_conf, w_conf_nxt;
  logic [AHEAD_W-1:0]        r_ahead, w_ahead_nxt;
  logic [BA_ADDR_SIZE-1:0]   r_next_pref, w_next_nxt;
  logic                      r_qvalid, w_qvalid_nxt;
  logic [1:0]                r_qop, w_qop_nxt;
  logic [BA_ADDR_SIZE-1:0]   r_qaddr, w_qaddr_nxt;
  logic                      r_flush, w_flush_nxt;

  logic [BA_ADDR_SIZE-1:0]   w_aligned, w_delta, w_stride_ext;
  logic                      w_delta_zero, w_delta_in_range, w_delta_match;
  logic [CONF_W-1:0]         w_conf_inc;
  logic                      w_page_ok, w_can_issue;

  assign w_aligned        = {demAddr[BA_ADDR_SIZE-1:LOG_BLOCK_DATA_BYTES], LOG_BLOCK_DATA_BYTES'(0)};
  assign w_delta          = w_aligned - r_last_addr;
  assign w_stride_ext     = {{(BA_ADDR_SIZE-STRIDE_BITS){r_stride[STRIDE_BITS-1]}}, r_stride};
  assign w_delta_zero     = (w_delta == '0);
  // Fits in signed STRIDE_BITS when all bits above the sign bit replicate it.
  assign w_delta_in_range = (&w_delta[BA_ADDR_SIZE-1:STRIDE_BITS-1]) | ~(|w_delta[BA_ADDR_SIZE-1:STRIDE_BITS-1]);
  assign w_delta_match    = (w_delta == w_stride_ext);
  assign w_conf_inc       = r_conf + CONF_W'(1);

`ifdef PREFETCH_PAGE_BOUND_EN
  assign w_page_ok = (r_next_pref[BA_ADDR_SIZE-1:PAGE_LOG] == r_last_addr[BA_ADDR_SIZE-1:PAGE_LOG]);
`else
  assign w_page_ok = 1'b1;
`endif

  assign w_can_issue = (r_state == S_ACTIVE) && !demValid && (r_ahead < DEPTH_L) && !queueFull &&
                       (32'(outstandingReqCnt) < MAX_OUTSTANDING) && w_page_ok;

  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last_addr;
    w_stride_nxt = r_stride;
    w_conf_nxt   = r_conf;
    w_ahead_nxt  = r_ahead;
    w_next_nxt   = r_next_pref;
    w_qvalid_nxt = 1'b0;
    w_qop_nxt    = 2'd0;
    w_qaddr_nxt  = '0;
    w_flush_nxt  = 1'b0;
    if (demValid) begin
      w_qvalid_nxt = 1'b1;
      w_qop_nxt    = 2'd1;
      w_qaddr_nxt  = w_aligned;
    end
    case (r_state)
      S_IDLE: begin
        if (demValid) begin
          w_last_nxt  = w_aligned;
          w_conf_nxt  = '0;
          w_state_nxt = S_TRAIN;
        end
      end
      S_TRAIN: begin
        if (demValid && !w_delta_zero) begin
          w_last_nxt = w_aligned;
          if (!w_delta_in_range) begin
            w_stride_nxt = '0;
            w_conf_nxt   = '0;
          end else begin
            if (w_delta_match) begin
              w_conf_nxt = w_conf_inc;
            end else begin
              w_stride_nxt = w_delta[STRIDE_BITS-1:0];
              w_conf_nxt   = CONF_W'(1);
            end
            // On activation the new stride equals delta in both branches.
            if ((w_delta_match && w_conf_inc == CONF_THR_L) || (!w_delta_match && CONF_THRESHOLD == 1)) begin
              w_state_nxt = S_ACTIVE;
              w_next_nxt  = w_aligned + w_delta;
              w_ahead_nxt = '0;
            end
          end
        end
      end
      S_ACTIVE: begin
        if (demValid) begin
          if (!w_delta_zero) begin
            w_last_nxt = w_aligned;
            if (w_delta_match) begin
              w_ahead_nxt = (r_ahead == '0) ? '0 : r_ahead - AHEAD_W'(1);
            end else begin
              w_flush_nxt  = 1'b1;
              w_state_nxt  = S_TRAIN;
              w_stride_nxt = w_delta_in_range ? w_delta[STRIDE_BITS-1:0] : '0;
              w_conf_nxt   = CONF_W'(1);
              w_ahead_nxt  = '0;
            end
          end
        end else if (w_can_issue) begin
          w_qvalid_nxt = 1'b1;
          w_qop_nxt    = 2'd2;
          w_qaddr_nxt  = r_next_pref;
          w_next_nxt   = r_next_pref + w_stride_ext;
          w_ahead_nxt  = r_ahead + AHEAD_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last_addr <= '0;
      r_stride    <= '0;
      r_conf      <= '0;
      r_ahead     <= '0;
      r_next_pref <= '0;
      r_qvalid    <= 1'b0;
      r_qop       <= 2'd0;
      r_qaddr     <= '0;
      r_flush     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_addr <= w_last_nxt;
      r_stride    <= w_stride_nxt;
      r_conf      <= w_conf_nxt;
      r_ahead     <= w_ahead_nxt;
      r_next_pref <= w_next_nxt;
      r_qvalid    <= w_qvalid_nxt;
      r_qop       <= w_qop_nxt;
      r_qaddr     <= w_qaddr_nxt;
      r_flush     <= w_flush_nxt;
    end
  end

  assign qValid    = r_qvalid;
  assign qOpcode   = r_qop;
  assign qAddr     = r_qaddr;
  assign flush     = r_flush;
  assign strideOut = r_stride;
  assign active    = (r_state == S_ACTIVE);

endmodule

// File: tb/tb_prefetch_stride_issuer.sv
// tb/tb_prefetch_stride_issuer.sv - vector table, corner sequences and randomized model check.
module tb_prefetch_stride_issuer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        demValid = 1'b0;
  logic [63:0] demAddr = '0;
  logic        queueFull = 1'b0;
  logic [6:0]  outstandingReqCnt = '0;
  logic        qValid;
  logic [1:0]  qOpcode;
  logic [63:0] qAddr;
  logic        flush;
  logic [15:0] strideOut;
  logic        active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prefetch_stride_issuer dut (
    .clk(clk), .reset(reset), .demValid(demValid), .demAddr(demAddr),
    .queueFull(queueFull), .outstandingReqCnt(outstandingReqCnt),
    .qValid(qValid), .qOpcode(qOpcode), .qAddr(qAddr), .flush(flush),
    .strideOut(strideOut), .active(active)
  );

  // Reference model: mode 0=idle, 1=train, 2=active; stride kept as a plain signed integer.
  int          m_mode;
  logic [63:0] m_last, m_next;
  longint      m_stride;
  int          m_conf, m_ahead;
  logic        e_valid, e_flush, e_active;
  logic [1:0]  e_op;
  logic [63:0] e_addr;
  logic [15:0] e_stride;

  task automatic model(input bit rst, input bit dv, input logic [63:0] da, input bit qf, input int cnt);
    logic [63:0] al;
    longint      d;
    bit          fits;
    al = da & ~64'h3F;
    d = longint'(al - m_last);
    fits = (d >= -32768) && (d <= 32767);
    e_valid = 0; e_op = 0; e_addr = 0; e_flush = 0;
    if (rst) begin
      m_mode = 0; m_last = 0; m_next = 0; m_stride = 0; m_conf = 0; m_ahead = 0;
    end else if (dv) begin
      e_valid = 1; e_op = 1; e_addr = al;
      if (m_mode == 0) begin
        m_last = al; m_conf = 0; m_mode = 1;
      end else if (d != 0) begin
        m_last = al;
        if (m_mode == 1) begin
          if (!fits) begin m_stride = 0; m_conf = 0; end
          else begin
            if (d == m_stride) m_conf++;
            else begin m_stride = d; m_conf = 1; end
            if (m_conf >= 2) begin m_mode = 2; m_next = al + 64'(m_stride); m_ahead = 0; end
          end
        end else if (d == m_stride) begin
          if (m_ahead > 0) m_ahead--;
        end else begin
          e_flush = 1; m_mode = 1; m_stride = fits ? d : 0; m_conf = 1; m_ahead = 0;
        end
      end
    end else if (m_mode == 2 && m_ahead < 4 && !qf && cnt < 8) begin
      e_valid = 1; e_op = 2; e_addr = m_next;
      m_next = m_next + 64'(m_stride);
      m_ahead++;
    end
    e_active = (m_mode == 2);
    e_stride = m_stride[15:0];
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit dv, input logic [63:0] da, input bit qf, input int cnt);
    reset = rst; demValid = dv; demAddr = da; queueFull = qf; outstandingReqCnt = 7'(cnt);
    model(rst, dv, da, qf, cnt);
    @(posedge clk); #1;
    check("model_qValid", 64'(qValid), 64'(e_valid));
    check("model_qOpcode", 64'(qOpcode), 64'(e_op));
    check("model_qAddr", qAddr, e_addr);
    check("model_flush", 64'(flush), 64'(e_flush));
    check("model_active", 64'(active), 64'(e_active));
    check("model_strideOut", 64'(strideOut), 64'(e_stride));
  endtask

  typedef struct {
    bit          rst;
    bit          dv;
    logic [63:0] addr;
    bit          ev;
    logic [1:0]  eop;
    logic [63:0] ea;
    bit          ef;
    bit          eact;
    logic [15:0] es;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [63:0] cur;
    longint      st;
    longint      strides[6];
    bit          qf;
    int          cnt, r;

    strides = '{64'sh40, -64'sh40, 64'sh80, -64'shC0, 64'sh0, 64'sh200000};
    tbl[0]  = '{1, 0, 64'h0,    0, 2'd0, 64'h0,    0, 0, 16'h0};
    tbl[1]  = '{0, 1, 64'h1000, 1, 2'd1, 64'h1000, 0, 0, 16'h0};
    tbl[2]  = '{0, 1, 64'h1040, 1, 2'd1, 64'h1040, 0, 0, 16'h40};
    tbl[3]  = '{0, 1, 64'h1080, 1, 2'd1, 64'h1080, 0, 1, 16'h40};
    tbl[4]  = '{0, 0, 64'h0,    1, 2'd2, 64'h10C0, 0, 1, 16'h40};
    tbl[5]  = '{0, 0, 64'h0,    1, 2'd2, 64'h1100, 0, 1, 16'h40};
    tbl[6]  = '{0, 0, 64'h0,    1, 2'd2, 64'h1140, 0, 1, 16'h40};
    tbl[7]  = '{0, 0, 64'h0,    1, 2'd2, 64'h1180, 0, 1, 16'h40};
    tbl[8]  = '{0, 0, 64'h0,    0, 2'd0, 64'h0,    0, 1, 16'h40};
    tbl[9]  = '{0, 1, 64'h2000, 1, 2'd1, 64'h2000, 1, 0, 16'hF80};
    tbl[10] = '{0, 0, 64'h0,    0, 2'd0, 64'h0,    0, 0, 16'hF80};

    m_mode = 0; m_last = 0; m_next = 0; m_stride = 0; m_conf = 0; m_ahead = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].rst, tbl[i].dv, tbl[i].addr, 0, 0);
      check($sformatf("tbl%0d_qValid", i), 64'(qValid), 64'(tbl[i].ev));
      check($sformatf("tbl%0d_qOpcode", i), 64'(qOpcode), 64'(tbl[i].eop));
      check($sformatf("tbl%0d_qAddr", i), qAddr, tbl[i].ea);
      check($sformatf("tbl%0d_flush", i), 64'(flush), 64'(tbl[i].ef));
      check($sformatf("tbl%0d_active", i), 64'(active), 64'(tbl[i].eact));
      check($sformatf("tbl%0d_strideOut", i), 64'(strideOut), 64'(tbl[i].es));
    end

    // queueFull held through training blocks prefetch until released
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 64'h1000, 1, 0);
    cyc(0, 1, 64'h1040, 1, 0);
    cyc(0, 1, 64'h1080, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      check("qfull_blocked", 64'(qValid), 64'h0);
    end
    cyc(0, 0, 0, 0, 0);
    check("qfull_release_op", 64'(qOpcode), 64'h2);
    check("qfull_release_addr", qAddr, 64'h10C0);

    // negative stride
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 64'h3000, 0, 0);
    cyc(0, 1, 64'h2FC0, 0, 0);
    cyc(0, 1, 64'h2F80, 0, 0);
    check("neg_stride", 64'(strideOut), 64'hFFC0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      check($sformatf("neg_pref%0d", i), qAddr, 64'h2F40 - 64'(i * 'h40));
    end

    // demand wins the free issue slot; prefetch follows at the same address
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 64'h1000, 0, 0);
    cyc(0, 1, 64'h1040, 0, 0);
    cyc(0, 1, 64'h1080, 0, 0);
    cyc(0, 1, 64'h10C0, 0, 0);
    check("arb_demand_op", 64'(qOpcode), 64'h1);
    cyc(0, 0, 0, 0, 0);
    check("arb_pref_op", 64'(qOpcode), 64'h2);
    check("arb_pref_addr", qAddr, 64'h10C0);

    // reset mid-ACTIVE, then restart from IDLE
    cyc(1, 1, 64'h1100, 0, 0);
    check("rst_qValid", 64'(qValid), 64'h0);
    check("rst_active", 64'(active), 64'h0);
    check("rst_stride", 64'(strideOut), 64'h0);
    cyc(0, 1, 64'h5000, 0, 0);
    check("restart_addr", qAddr, 64'h5000);
    cyc(0, 0, 0, 0, 0);
    check("restart_idle", 64'(qValid), 64'h0);

    // randomized traffic against the model
    cur = 64'h40000; st = 64'sh40;
    for (int i = 0; i < 4000; i++) begin
      r   = $urandom_range(99);
      qf  = ($urandom_range(4) == 0);
      cnt = $urandom_range(11);
      if (r < 1) cyc(1, 0, 0, 0, 0);
      else if (r < 45) begin
        if ($urandom_range(9) == 0) st = strides[$urandom_range(5)];
        if ($urandom_range(24) == 0) cur = {$urandom, $urandom};
        else cur = cur + 64'(st);
        cyc(0, 1, cur | 64'($urandom_range(63)), qf, cnt);
      end else cyc(0, 0, 64'($urandom), qf, cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
